// File: rtl/load_trans_buffer_if.sv
// rtl/load_trans_buffer_if.sv - load/cache/writeback signal bundle for load_trans_buffer
//
// Purpose: groups the load-unit request, cache response, flush and scoreboard
// writeback signals of load_trans_buffer. Signal names and _i/_o suffixes are
// taken from the buffer's point of view.
// Modports:
//   slave  - the buffer itself (requests/responses in, ready/id/result out)
//   master - the surrounding pipeline (load unit, cache, scoreboard)
interface load_trans_buffer_if #(
  parameter int NR_ENTRIES = 2,
  parameter int XLEN       = 64,
  parameter int TRANS_ID_W = 3
);
  localparam int ID_W  = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1;
  localparam int OFF_W = $clog2(XLEN / 8);

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [TRANS_ID_W-1:0] req_trans_id_i;
  logic [OFF_W-1:0]      req_offset_i;
  logic [1:0]            req_size_i;
  logic                  req_signed_i;
  logic [ID_W-1:0]       req_id_o;
  logic                  rsp_valid_i;
  logic [ID_W-1:0]       rsp_id_i;
  logic [XLEN-1:0]       rsp_data_i;
  logic                  flush_i;
  logic                  result_valid_o;
  logic [TRANS_ID_W-1:0] result_trans_id_o;
  logic [XLEN-1:0]       result_data_o;
  logic                  empty_o;

  modport slave (
    input  req_valid_i, req_trans_id_i, req_offset_i, req_size_i, req_signed_i,
    input  rsp_valid_i, rsp_id_i, rsp_data_i, flush_i,
    output req_ready_o, req_id_o, result_valid_o, result_trans_id_o,
    output result_data_o, empty_o
  );

  modport master (
    output req_valid_i, req_trans_id_i, req_offset_i, req_size_i, req_signed_i,
    output rsp_valid_i, rsp_id_i, rsp_data_i, flush_i,
    input  req_ready_o, req_id_o, result_valid_o, result_trans_id_o,
    input  result_data_o, empty_o
  );
endinterface

// File: rtl/load_trans_buffer.sv
// rtl/load_trans_buffer.sv - outstanding-load tracker between load unit and data cache
//
// Purpose: each accepted load takes a slot whose index is the cache request ID.
// The slot keeps the scoreboard transaction ID and alignment metadata; when the
// cache answers, the value is extracted, extended and written back one cycle later.
// Ports:
//   clk_i   - clock, rising edge
//   rst_ni  - asynchronous active-low reset
//   bus     - load_trans_buffer_if.slave: request/allocation, cache response,
//             flush, registered writeback result and empty flag
module load_trans_buffer #(
  parameter int NR_ENTRIES = 2,
  parameter int XLEN       = 64,
  parameter int TRANS_ID_W = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  load_trans_buffer_if.slave   bus
);
  localparam int ID_W  = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1;
  localparam int OFF_W = $clog2(XLEN / 8);

  // Per-slot state
  logic [NR_ENTRIES-1:0] valid_q, valid_d;
  logic [NR_ENTRIES-1:0] killed_q, killed_d;
  logic [TRANS_ID_W-1:0] trans_id_q [NR_ENTRIES];
  logic [TRANS_ID_W-1:0] trans_id_d [NR_ENTRIES];
  logic [OFF_W-1:0]      offset_q   [NR_ENTRIES];
  logic [OFF_W-1:0]      offset_d   [NR_ENTRIES];
  logic [1:0]            size_q     [NR_ENTRIES];
  logic [1:0]            size_d     [NR_ENTRIES];
  logic [NR_ENTRIES-1:0] signed_q, signed_d;

  // Writeback register
  logic                  result_valid_q, result_valid_d;
  logic [TRANS_ID_W-1:0] result_trans_id_q, result_trans_id_d;
  logic [XLEN-1:0]       result_data_q, result_data_d;

  // Allocation
  logic                  free_found;
  logic [ID_W-1:0]       alloc_id;
  logic                  alloc;

  // Response slot selection
  logic                  rsp_hit;
  logic                  sel_killed;
  logic [TRANS_ID_W-1:0] sel_trans_id;
  logic [OFF_W-1:0]      sel_offset;
  logic [1:0]            sel_size;
  logic                  sel_signed;

  // Extraction
  logic [XLEN-1:0]       shifted;
  logic [XLEN-1:0]       keep_mask;
  logic                  sign_bit;
  logic [XLEN-1:0]       ext_data;

  // Lowest free slot; scanning downward lets the lowest index win.
  // Uses registered state only, so a slot freed this cycle is not visible yet.
  always_comb begin
    free_found = 1'b0;
    alloc_id   = '0;
    for (int i = NR_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        alloc_id   = ID_W'(i);
      end
    end
  end

  assign alloc = bus.req_valid_i && free_found && !bus.flush_i;

  // Decode the answered slot with a compare loop so IDs beyond NR_ENTRIES
  // (non power-of-two depths) simply miss instead of indexing out of range.
  always_comb begin
    rsp_hit      = 1'b0;
    sel_killed   = 1'b0;
    sel_trans_id = '0;
    sel_offset   = '0;
    sel_size     = '0;
    sel_signed   = 1'b0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      if (bus.rsp_id_i == ID_W'(i)) begin
        rsp_hit      = bus.rsp_valid_i && valid_q[i];
        sel_killed   = killed_q[i];
        sel_trans_id = trans_id_q[i];
        sel_offset   = offset_q[i];
        sel_size     = size_q[i];
        sel_signed   = signed_q[i];
      end
    end
  end

  // Shift the addressed bytes down, keep the access width, then fill the upper
  // bits with ones when a signed value is negative. The mask form avoids
  // zero-width replications when XLEN is 32.
  always_comb begin
    shifted = bus.rsp_data_i >> {sel_offset, 3'b000};
    case (sel_size)
      2'd0: begin
        keep_mask = XLEN'(8'hFF);
        sign_bit  = shifted[7];
      end
      2'd1: begin
        keep_mask = XLEN'(16'hFFFF);
        sign_bit  = shifted[15];
      end
      2'd2: begin
        keep_mask = XLEN'(32'hFFFF_FFFF);
        sign_bit  = shifted[31];
      end
      default: begin
        keep_mask = '1;
        sign_bit  = shifted[XLEN-1];
      end
    endcase
    ext_data = shifted & keep_mask;
    if (sel_signed && sign_bit) begin
      ext_data = ext_data | ~keep_mask;
    end
  end

  // Slot next state. Allocation never coincides with a flush and never hits
  // a slot that is being answered (that slot is still valid in registered state).
  always_comb begin
    valid_d    = valid_q;
    killed_d   = killed_q;
    trans_id_d = trans_id_q;
    offset_d   = offset_q;
    size_d     = size_q;
    signed_d   = signed_q;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      // Killed slots stay occupied so the cache ID is not reused before the reply.
      if (bus.flush_i && valid_q[i]) begin
        killed_d[i] = 1'b1;
      end
      if (rsp_hit && (bus.rsp_id_i == ID_W'(i))) begin
        valid_d[i] = 1'b0;
      end
      if (alloc && (alloc_id == ID_W'(i))) begin
        valid_d[i]    = 1'b1;
        killed_d[i]   = 1'b0;
        trans_id_d[i] = bus.req_trans_id_i;
        offset_d[i]   = bus.req_offset_i;
        size_d[i]     = bus.req_size_i;
        signed_d[i]   = bus.req_signed_i;
      end
    end
  end

  // Writeback: trans ID and data hold their value between pulses.
  always_comb begin
    result_valid_d    = rsp_hit && !sel_killed && !bus.flush_i;
    result_trans_id_d = result_trans_id_q;
    result_data_d     = result_data_q;
    if (result_valid_d) begin
      result_trans_id_d = sel_trans_id;
      result_data_d     = ext_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q           <= '0;
      killed_q          <= '0;
      signed_q          <= '0;
      for (int i = 0; i < NR_ENTRIES; i++) begin
        trans_id_q[i] <= '0;
        offset_q[i]   <= '0;
        size_q[i]     <= '0;
      end
      result_valid_q    <= 1'b0;
      result_trans_id_q <= '0;
      result_data_q     <= '0;
    end else begin
      valid_q           <= valid_d;
      killed_q          <= killed_d;
      signed_q          <= signed_d;
      for (int i = 0; i < NR_ENTRIES; i++) begin
        trans_id_q[i] <= trans_id_d[i];
        offset_q[i]   <= offset_d[i];
        size_q[i]     <= size_d[i];
      end
      result_valid_q    <= result_valid_d;
      result_trans_id_q <= result_trans_id_d;
      result_data_q     <= result_data_d;
    end
  end

  assign bus.req_ready_o       = free_found && !bus.flush_i;
  assign bus.req_id_o          = alloc_id;
  assign bus.result_valid_o    = result_valid_q;
  assign bus.result_trans_id_o = result_trans_id_q;
  assign bus.result_data_o     = result_data_q;
  assign bus.empty_o           = ~|valid_q;
endmodule

// File: tb/tb_load_trans_buffer.sv
// tb/tb_load_trans_buffer.sv - directed self-checking bench for load_trans_buffer
module tb_load_trans_buffer;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  load_trans_buffer_if #(.NR_ENTRIES(2), .XLEN(64), .TRANS_ID_W(3)) bus ();

  load_trans_buffer #(.NR_ENTRIES(2), .XLEN(64), .TRANS_ID_W(3)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Step to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] tid, input logic [2:0] off, input logic [1:0] sz,
                     input logic sgn);
    bus.req_valid_i    = 1'b1;
    bus.req_trans_id_i = tid;
    bus.req_offset_i   = off;
    bus.req_size_i     = sz;
    bus.req_signed_i   = sgn;
  endtask

  task automatic rsp(input logic id, input logic [63:0] data);
    bus.rsp_valid_i = 1'b1;
    bus.rsp_id_i    = id;
    bus.rsp_data_i  = data;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.req_valid_i    = 1'b0;
    bus.req_trans_id_i = '0;
    bus.req_offset_i   = '0;
    bus.req_size_i     = '0;
    bus.req_signed_i   = 1'b0;
    bus.rsp_valid_i    = 1'b0;
    bus.rsp_id_i       = '0;
    bus.rsp_data_i     = '0;
    bus.flush_i        = 1'b0;

    // Reset state
    #2;
    chk("rst_result_valid", 64'(bus.result_valid_o), 64'd0);
    chk("rst_result_tid", 64'(bus.result_trans_id_o), 64'd0);
    chk("rst_result_data", bus.result_data_o, 64'd0);
    chk("rst_empty", 64'(bus.empty_o), 64'd1);
    chk("rst_ready", 64'(bus.req_ready_o), 64'd1);
    chk("rst_req_id", 64'(bus.req_id_o), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Single signed word load at offset 4
    req(3'd5, 3'd4, 2'd2, 1'b1);
    #1;
    chk("t1_req_id", 64'(bus.req_id_o), 64'd0);
    tick();
    bus.req_valid_i = 1'b0;
    #1;
    chk("t1_empty_busy", 64'(bus.empty_o), 64'd0);
    chk("t1_next_id", 64'(bus.req_id_o), 64'd1);
    rsp(1'b0, 64'h8000_0001_0000_0000);
    #1;
    chk("t1_no_early_result", 64'(bus.result_valid_o), 64'd0);
    tick();
    bus.rsp_valid_i = 1'b0;
    #1;
    chk("t1_result_valid", 64'(bus.result_valid_o), 64'd1);
    chk("t1_result_tid", 64'(bus.result_trans_id_o), 64'd5);
    chk("t1_result_data", bus.result_data_o, 64'hFFFF_FFFF_8000_0001);
    chk("t1_empty_after", 64'(bus.empty_o), 64'd1);
    tick();
    chk("t1_pulse_end", 64'(bus.result_valid_o), 64'd0);
    chk("t1_data_hold", bus.result_data_o, 64'hFFFF_FFFF_8000_0001);

    // Fill and wrap: double unsigned in slot 0, signed half in slot 1
    req(3'd1, 3'd0, 2'd3, 1'b0);
    #1;
    chk("t2_id_a", 64'(bus.req_id_o), 64'd0);
    tick();
    req(3'd2, 3'd0, 2'd1, 1'b1);
    #1;
    chk("t2_id_b", 64'(bus.req_id_o), 64'd1);
    tick();
    req(3'd3, 3'd0, 2'd0, 1'b0);
    #1;
    chk("t2_full_ready", 64'(bus.req_ready_o), 64'd0);
    rsp(1'b1, 64'h0000_0000_0000_8123);
    #1;
    chk("t2_no_same_cycle_reuse", 64'(bus.req_ready_o), 64'd0);
    tick();
    bus.rsp_valid_i = 1'b0;
    #1;
    chk("t2_res_b_valid", 64'(bus.result_valid_o), 64'd1);
    chk("t2_res_b_tid", 64'(bus.result_trans_id_o), 64'd2);
    chk("t2_res_b_data", bus.result_data_o, 64'hFFFF_FFFF_FFFF_8123);
    chk("t2_reuse_ready", 64'(bus.req_ready_o), 64'd1);
    chk("t2_reuse_id", 64'(bus.req_id_o), 64'd1);
    tick();
    bus.req_valid_i = 1'b0;
    rsp(1'b0, 64'h0123_4567_89AB_CDEF);
    #1;
    chk("t2_full_again", 64'(bus.req_ready_o), 64'd0);
    tick();
    // Simultaneous new request (slot 0) and response (slot 1)
    req(3'd4, 3'd7, 2'd0, 1'b0);
    rsp(1'b1, 64'h0000_0000_0000_00F0);
    #1;
    chk("t2_res_a_tid", 64'(bus.result_trans_id_o), 64'd1);
    chk("t2_res_a_data", bus.result_data_o, 64'h0123_4567_89AB_CDEF);
    chk("t2_c_id", 64'(bus.req_id_o), 64'd0);
    tick();
    bus.req_valid_i = 1'b0;
    rsp(1'b0, 64'hAB00_0000_0000_0000);
    #1;
    chk("t2_res_c_tid", 64'(bus.result_trans_id_o), 64'd3);
    chk("t2_res_c_data", bus.result_data_o, 64'h0000_0000_0000_00F0);
    tick();
    bus.rsp_valid_i = 1'b0;
    #1;
    chk("t3_byte_valid", 64'(bus.result_valid_o), 64'd1);
    chk("t3_byte_tid", 64'(bus.result_trans_id_o), 64'd4);
    chk("t3_byte_data", bus.result_data_o, 64'h0000_0000_0000_00AB);
    chk("t3_empty", 64'(bus.empty_o), 64'd1);

    // Flush with two loads outstanding
    tick();
    req(3'd6, 3'd0, 2'd2, 1'b0);
    tick();
    req(3'd7, 3'd0, 2'd2, 1'b0);
    tick();
    bus.req_valid_i = 1'b0;
    bus.flush_i     = 1'b1;
    #1;
    chk("t4_ready_in_flush", 64'(bus.req_ready_o), 64'd0);
    tick();
    bus.flush_i = 1'b0;
    #1;
    chk("t4_ready_killed", 64'(bus.req_ready_o), 64'd0);
    chk("t4_empty_killed", 64'(bus.empty_o), 64'd0);
    rsp(1'b0, 64'h1111_2222_3333_4444);
    tick();
    rsp(1'b1, 64'h5555_6666_7777_8888);
    #1;
    chk("t4_no_result_0", 64'(bus.result_valid_o), 64'd0);
    chk("t4_empty_one_left", 64'(bus.empty_o), 64'd0);
    tick();
    bus.rsp_valid_i = 1'b0;
    #1;
    chk("t4_no_result_1", 64'(bus.result_valid_o), 64'd0);
    chk("t4_empty_after", 64'(bus.empty_o), 64'd1);
    chk("t4_tid_hold", 64'(bus.result_trans_id_o), 64'd4);

    // Flush in the same cycle as the response
    req(3'd2, 3'd0, 2'd0, 1'b0);
    tick();
    bus.req_valid_i = 1'b0;
    rsp(1'b0, 64'h0000_0000_0000_0055);
    bus.flush_i = 1'b1;
    tick();
    bus.rsp_valid_i = 1'b0;
    bus.flush_i     = 1'b0;
    #1;
    chk("t5_flush_rsp_result", 64'(bus.result_valid_o), 64'd0);
    chk("t5_flush_rsp_empty", 64'(bus.empty_o), 64'd1);

    // Stray response to an unallocated slot while slot 0 is busy
    req(3'd3, 3'd0, 2'd0, 1'b1);
    tick();
    bus.req_valid_i = 1'b0;
    rsp(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    bus.rsp_valid_i = 1'b0;
    #1;
    chk("t5_stray_result", 64'(bus.result_valid_o), 64'd0);
    chk("t5_stray_empty", 64'(bus.empty_o), 64'd0);
    chk("t5_stray_id", 64'(bus.req_id_o), 64'd1);
    rsp(1'b0, 64'h0000_0000_0000_007F);
    tick();
    bus.rsp_valid_i = 1'b0;
    #1;
    chk("t5_slot0_valid", 64'(bus.result_valid_o), 64'd1);
    chk("t5_slot0_tid", 64'(bus.result_trans_id_o), 64'd3);
    chk("t5_slot0_data", bus.result_data_o, 64'h0000_0000_0000_007F);

    // Asynchronous reset with two loads outstanding
    req(3'd1, 3'd0, 2'd3, 1'b0);
    tick();
    req(3'd2, 3'd0, 2'd3, 1'b0);
    tick();
    bus.req_valid_i = 1'b0;
    #1;
    chk("t6_busy_before", 64'(bus.empty_o), 64'd0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_async_empty", 64'(bus.empty_o), 64'd1);
    chk("t6_async_result", 64'(bus.result_valid_o), 64'd0);
    chk("t6_async_tid", 64'(bus.result_trans_id_o), 64'd0);
    chk("t6_async_ready", 64'(bus.req_ready_o), 64'd1);
    tick();
    rst_n = 1'b1;
    rsp(1'b0, 64'h0000_0000_0000_0099);
    tick();
    rsp(1'b1, 64'h0000_0000_0000_0088);
    #1;
    chk("t6_late_rsp0", 64'(bus.result_valid_o), 64'd0);
    tick();
    bus.rsp_valid_i = 1'b0;
    #1;
    chk("t6_late_rsp1", 64'(bus.result_valid_o), 64'd0);
    chk("t6_late_empty", 64'(bus.empty_o), 64'd1);
    chk("t6_late_data", bus.result_data_o, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/load_trans_buffer.md
# load_trans_buffer

Tracks outstanding loads between the load unit and the data cache read port. Each accepted load gets a buffer slot; the slot index is the cache request ID. Each slot records the scoreboard transaction ID and alignment metadata. When the cache answers, the block extracts and extends the loaded value and returns it to the scoreboard one cycle later. Its depth and data width come from the core's NrLoadBufEntries and XLEN configuration fields.

## Interface
- NR_ENTRIES, 2: number of outstanding loads; legal range 1..8
- XLEN, 64: data width; 32 or 64
- TRANS_ID_W, 3: scoreboard transaction ID width
- ID_W, max(1, $clog2(NR_ENTRIES)): cache request ID width (derived)

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_ni  in  1  reset; asynchronous, active-low
- req_valid_i  in  1  load unit issues a load
- req_ready_o  out  1  a free slot exists and flush_i is low
- req_trans_id_i  in  TRANS_ID_W  scoreboard ID of the load
- req_offset_i  in  $clog2(XLEN/8)  byte offset inside the XLEN word
- req_size_i  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double (3 is illegal when XLEN=32)
- req_signed_i  in  1  1 = sign-extend, 0 = zero-extend
- req_id_o  out  ID_W  index of the slot allocated this cycle (combinational)
- rsp_valid_i  in  1  cache returns data
- rsp_id_i  in  ID_W  slot being answered
- rsp_data_i  in  XLEN  raw aligned word from the cache
- flush_i  in  1  pipeline flush; kill all outstanding loads
- result_valid_o  out  1  writeback valid (registered)
- result_trans_id_o  out  TRANS_ID_W  scoreboard ID of the result
- result_data_o  out  XLEN  extracted, extended load data
- empty_o  out  1  no slot occupied

## Operation
- Per-slot state: valid, killed, trans_id, offset, size, signed.
- Allocation:
  - req_ready_o = !flush_i && at least one slot has valid == 0, computed from registered state only.
  - req_id_o = lowest-index free slot.
  - On req_valid_i && req_ready_o: slot.valid <= 1, slot.killed <= 0, metadata is stored.
- Response with rsp_valid_i and slot rsp_id_i valid:
  - slot.valid <= 0.
  - If slot.killed == 0 and flush_i == 0: next cycle result_valid_o = 1, with the stored trans_id and the extracted data.
  - Otherwise no result is produced.
- Response to a slot with valid == 0: ignored, no state change.
- Flush: every slot with valid == 1 gets killed <= 1. A killed slot stays occupied until its response arrives, so a cache ID is never reused while a reply is pending.
- Data extraction:
  - shifted = rsp_data_i >> (8 * stored offset).
  - Take the low 8/16/32/64 bits according to size.
  - Sign- or zero-extend to XLEN.
  - Offsets that are misaligned for the size are the load unit's responsibility and are not checked.
- A slot freed by a response becomes allocatable from the next cycle, not the same cycle.
- Simultaneous request and response on different slots: both take effect.
- A response and a new request cannot target the same slot in the same cycle, because that slot is still valid in registered state.
- empty_o = no slot has valid == 1; killed slots count as occupied.

## Timing
- Reset (rst_ni low, asynchronous):
  - All slots valid = 0, killed = 0.
  - result_valid_o = 0, result_trans_id_o = 0, result_data_o = 0.
  - empty_o = 1, req_ready_o = 1, req_id_o = 0.
- Reset during operation: all outstanding loads are forgotten, and later responses to them are ignored because their slots are invalid.
- Request to cache ID: combinational, 0 cycles.
- Response to result: exactly 1 cycle (rsp in cycle N gives result_valid_o in cycle N+1).
- result_valid_o is a single-cycle pulse per response; there is no backpressure, so the scoreboard always accepts it.
- result_trans_id_o and result_data_o hold their last value when result_valid_o = 0.
- flush_i asserted in the same cycle as a response suppresses that result. A result already registered, visible in that cycle, is still delivered.
- Full condition: NR_ENTRIES slots occupied (valid, killed or not) forces req_ready_o = 0.

## Test plan
- Reset then single load:
  - Stimulus: trans_id 5, offset 4, size word, signed; response on slot 0 with data 0x8000_0001_0000_0000.
  - Required: req_id_o = 0; one cycle after the response, result_valid_o = 1, trans_id 5, data 0xFFFF_FFFF_8000_0001.
- Fill and wrap:
  - Stimulus: issue 2 loads (IDs 0, 1); answer slot 1 first; issue a third load.
  - Required: req_ready_o = 0 after the second load; results come back in response order; the third load gets ID 1 one cycle after its response, not the same cycle.
- Zero-extend byte:
  - Stimulus: offset 7, size byte, unsigned, data 0xAB00_0000_0000_0000.
  - Required: result 0x0000_0000_0000_00AB.
- Flush:
  - Stimulus: 2 loads outstanding, flush_i pulsed, then both responses arrive.
  - Required: req_ready_o = 0 and empty_o = 0 until both responses arrive; no result_valid_o; empty_o = 1 afterwards.
- Flush coincident with a response, plus a stray response:
  - Stimulus: flush_i and a response on the same cycle; separately, a response to an unallocated ID.
  - Required: no result in either case; state unchanged for the stray response.
- Asynchronous reset mid-flight:
  - Stimulus: rst_ni dropped between clock edges with 2 loads outstanding.
  - Required: empty_o = 1 and result_valid_o = 0 immediately; late responses ignored.
